// File: rtl/adc_capture_mc_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_mc_pkg
// Shared types and helpers for the multi-channel ADC capture block.
//   state_t      : capture FSM states (IDLE, CAPTURE, DRAIN)
//   PAT_CH_BITS  : width of the channel-number field in the test pattern
//   ch_width()   : width of a channel index, never less than 1
//   entry_width(): FIFO entry width, one sample-set plus its channel mask
// ---------------------------------------------------------------------------
package adc_capture_mc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Test pattern word: {channel[2:0], set_index[DATA_W-4:0]}
    localparam int PAT_CH_BITS = 3;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int entry_width(input int n, input int w);
        return n * w + n;
    endfunction

endpackage

// File: rtl/adc_capture_mc_fifo.sv
// ---------------------------------------------------------------------------
// adc_capture_mc_fifo
// Synchronous FIFO holding captured sample-sets. The head entry is presented
// combinationally on rd_data so the unpacker can start a set in the same
// cycle it pops it.
// Ports:
//   clk, rstn       : clock, synchronous active-low reset
//   push, wr_data   : write request / data (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the FIFO in one cycle
//   rd_data         : head entry
//   full, empty     : status flags
//   count           : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module adc_capture_mc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_mc.sv
// ---------------------------------------------------------------------------
// adc_capture_mc
// Captures cfg_len decimated sample-sets from NUM_CH parallel ADC channels,
// buffers them in a FIFO and unpacks the enabled channels into a
// valid/ready stream, lowest channel first.
// Optional feature macro: ADC_CAPTURE_MC_TEST_PATTERN_EN
//   defined     : cfg_test_mode=1 (latched at start) replaces channel data
//                 with {channel, set_index}
//   not defined : cfg_test_mode is ignored, adc_data is always captured
// Ports:
//   CLK, RSTN           : clock, synchronous active-low reset
//   adc_data, adc_valid : channel c at [c*DATA_W +: DATA_W], one-cycle qualifier
//   start, abort        : arm a capture / cancel immediately (flushes FIFO)
//   cfg_ch_mask/len/decim/test_mode : capture configuration, latched on start
//   out_data/out_ch/out_valid/out_ready/out_last : readout stream
//   busy, done          : run in progress / one-cycle completion pulse
//   overflow, clr_status: sticky dropped-set flag and its clear
// ---------------------------------------------------------------------------
module adc_capture_mc
    import adc_capture_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = 16
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_CH*DATA_W-1:0]     adc_data,
    input  logic                         adc_valid,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_CH-1:0]            cfg_ch_mask,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic [7:0]                   cfg_decim,
    input  logic                         cfg_test_mode,
    output logic [DATA_W-1:0]            out_data,
    output logic [ch_width(NUM_CH)-1:0]  out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    input  logic                         clr_status
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int ENT_W = entry_width(NUM_CH, DATA_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Control state
    state_t               state_reg;
    logic [NUM_CH-1:0]    mask_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [LEN_W-1:0]     kept_reg;
    logic [7:0]           decim_reg;
    logic [7:0]           decim_cnt_reg;
    logic                 overflow_reg;
    logic                 done_reg;

    // Unpacker state
    logic                 out_valid_reg;
    logic                 out_last_reg;
    logic [CH_W-1:0]      out_ch_reg;
    logic [DATA_W-1:0]    out_data_reg;
    logic [NUM_CH-1:0]    rem_reg;        // enabled channels still to emit
    logic [NUM_CH*DATA_W-1:0] cur_data_reg;
    logic                 last_set_reg;   // current set is the final one

    // FIFO interface
    logic [ENT_W-1:0]     fifo_rd;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [NUM_CH*DATA_W-1:0] cap_data;

    // Capture-side decode
    logic                 keep;
    logic                 push;
    logic                 drop;
    logic                 cap_end;
    logic                 full_eff;
    logic [CNT_W-1:0]     occupancy;

    // Unpacker decode
    logic                 accept;
    logic                 load_new;
    logic                 advance;
    logic                 last_entry;
    logic                 next_last_set;
    logic [NUM_CH-1:0]    src_mask;
    logic [NUM_CH-1:0]    next_rem;
    logic [NUM_CH*DATA_W-1:0] src_data;
    logic [CH_W-1:0]      sel_ch;
    logic [DATA_W-1:0]    sel_data;

`ifdef ADC_CAPTURE_MC_TEST_PATTERN_EN
    logic                             test_mode_reg;
    logic [DATA_W-PAT_CH_BITS-1:0]    set_idx_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pat
        assign cap_data[gi*DATA_W +: DATA_W] = test_mode_reg ?
            {PAT_CH_BITS'(gi), set_idx_reg} : adc_data[gi*DATA_W +: DATA_W];
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            test_mode_reg <= 1'b0;
            set_idx_reg   <= '0;
        end else if (state_reg == IDLE && start && !abort) begin
            test_mode_reg <= cfg_test_mode;
            set_idx_reg   <= '0;
        end else if (keep) begin
            set_idx_reg   <= set_idx_reg + 1'b1;
        end
    end
`else
    logic test_mode_unused;
    assign test_mode_unused = cfg_test_mode;
    assign cap_data         = adc_data;
`endif

    adc_capture_mc_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rstn    (RSTN),
        .push    (push),
        .wr_data ({mask_reg, cap_data}),
        .pop     (load_new),
        .flush   (abort),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The set being unpacked counts toward capacity, so DEPTH sets in
    // flight is the limit; a set arriving beyond that is dropped.
    always_comb begin
        keep      = (state_reg == CAPTURE) && adc_valid &&
                    (decim_cnt_reg == 8'd0) && !abort;
        occupancy = fifo_count + CNT_W'(out_valid_reg);
        full_eff  = fifo_full || (occupancy >= CNT_W'(DEPTH));
        push      = keep && !full_eff;
        drop      = keep && full_eff;
        cap_end   = keep && ((kept_reg + 1'b1) == len_reg);
    end

    always_comb begin
        accept   = out_valid_reg && out_ready;
        // Pop the next set in the same cycle the final beat of the current
        // set is taken, so consecutive sets stream without a bubble.
        load_new = (!out_valid_reg || (accept && rem_reg == '0)) &&
                   !fifo_empty && !abort;
        advance  = load_new || (accept && rem_reg != '0);
        src_mask = load_new ? fifo_rd[ENT_W-1 -: NUM_CH] : rem_reg;
        src_data = load_new ? fifo_rd[NUM_CH*DATA_W-1:0] : cur_data_reg;

        // Lowest enabled channel wins (descending scan, last write kept).
        sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                sel_ch = CH_W'(i);
            end
        end
        next_rem = src_mask & ~(NUM_CH'(1) << sel_ch);
        sel_data = src_data[sel_ch*DATA_W +: DATA_W];

        // The head set is final when nothing else is queued behind it, no
        // set is arriving now, and the capture window has closed.
        last_entry    = (fifo_count == CNT_W'(1)) && !push &&
                        ((state_reg == DRAIN) || cap_end);
        next_last_set = load_new ? last_entry : last_set_reg;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            len_reg       <= '0;
            kept_reg      <= '0;
            decim_reg     <= '0;
            decim_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
            out_data_reg  <= '0;
            rem_reg       <= '0;
            cur_data_reg  <= '0;
            last_set_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_status) begin
                overflow_reg <= 1'b0;
            end

            if (abort) begin
                state_reg     <= IDLE;
                kept_reg      <= '0;
                decim_cnt_reg <= '0;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                rem_reg       <= '0;
                last_set_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            mask_reg      <= cfg_ch_mask;
                            len_reg       <= cfg_len;
                            decim_reg     <= cfg_decim;
                            kept_reg      <= '0;
                            decim_cnt_reg <= '0;
                            // An empty run completes at once with no beats.
                            if (cfg_len == '0 || cfg_ch_mask == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (adc_valid) begin
                            decim_cnt_reg <= (decim_cnt_reg == decim_reg) ?
                                             8'd0 : decim_cnt_reg + 8'd1;
                        end
                        // Dropped sets still consume the window.
                        if (keep) begin
                            kept_reg <= kept_reg + 1'b1;
                        end
                        if (cap_end) begin
                            state_reg <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty && !out_valid_reg) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase

                if (advance) begin
                    out_valid_reg <= 1'b1;
                    out_ch_reg    <= sel_ch;
                    out_data_reg  <= sel_data;
                    rem_reg       <= next_rem;
                    cur_data_reg  <= src_data;
                    last_set_reg  <= next_last_set;
                    out_last_reg  <= next_last_set && (next_rem == '0);
                end else if (accept) begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_adc_capture_mc.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_mc
// Directed bench for adc_capture_mc (NUM_CH=4, DATA_W=18, DEPTH=4).
// Raw channel data for valid number v, channel c is 0x1000 + 16*v + c, so
// every accepted beat identifies the set and channel it came from.
// Build with ADC_CAPTURE_MC_TEST_PATTERN_EN to expect the test pattern in
// the test-mode run.
// ---------------------------------------------------------------------------
module tb_adc_capture_mc;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 16;
    localparam int CH_W   = 2;
`ifdef ADC_CAPTURE_MC_TEST_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic                       CLK = 1'b0;
    logic                       RSTN;
    logic [NUM_CH*DATA_W-1:0]   adc_data;
    logic                       adc_valid;
    logic                       start;
    logic                       abort;
    logic [NUM_CH-1:0]          cfg_ch_mask;
    logic [LEN_W-1:0]           cfg_len;
    logic [7:0]                 cfg_decim;
    logic                       cfg_test_mode;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_ch;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       busy;
    logic                       done;
    logic                       overflow;
    logic                       clr_status;

    always #5 CLK = ~CLK;

    adc_capture_mc #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .start         (start),
        .abort         (abort),
        .cfg_ch_mask   (cfg_ch_mask),
        .cfg_len       (cfg_len),
        .cfg_decim     (cfg_decim),
        .cfg_test_mode (cfg_test_mode),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .clr_status    (clr_status)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vcount   = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_beat_cyc = -1;
    int first_v_cyc   = -1;
    int first_ov_cyc  = -1;
    logic [31:0] beats [$];
    logic [31:0] exp_q [$];

    function automatic logic [NUM_CH*DATA_W-1:0] make_set(input int v);
        logic [NUM_CH*DATA_W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c*DATA_W +: DATA_W] = 18'(32'h1000 + v * 16 + c);
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] exp_val(input int s, input int c, input bit tm);
        if (tm && PAT_ON) begin
            return {3'(c), 15'(s)};
        end
        return 18'(32'h1000 + s * 16 + c);
    endfunction

    function automatic logic [31:0] mk_beat(input bit last, input int c, input logic [DATA_W-1:0] d);
        return {11'b0, last, 2'(c), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record what the DUT shows in the current cycle, then advance.
    task automatic step();
        adc_data = make_set(vcount);
        if (out_valid && out_ready) begin
            beats.push_back({11'b0, out_last, out_ch, out_data});
            last_beat_cyc = cyc;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (adc_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge CLK);
        #1;
        if (adc_valid) vcount++;
        cyc++;
    endtask

    task automatic tb_clear();
        beats.delete();
        exp_q.delete();
        vcount = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_beat_cyc = -1;
        first_v_cyc = -1;
        first_ov_cyc = -1;
    endtask

    task automatic begin_run(input logic [3:0] mask, input int len, input int decim, input bit tm);
        cfg_ch_mask   = mask;
        cfg_len       = 16'(len);
        cfg_decim     = 8'(decim);
        cfg_test_mode = tm;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_valids(input int n);
        adc_valid = 1'b1;
        repeat (n) step();
        adc_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (done_cnt == 0 && i < 200) begin
            step();
            i++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic add_set(input int s, input logic [3:0] mask, input bit tm, input bit last_set);
        int hi = 0;
        for (int c = 0; c < NUM_CH; c++) if (mask[c]) hi = c;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) exp_q.push_back(mk_beat(last_set && (c == hi), c, exp_val(s, c, tm)));
        end
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_beat_count"}, 32'(beats.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] a;
            a = (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF;
            $display("%s beat %0d: ch=%0d data=%05h last=%0b", tag, i, a[19:18], a[17:0], a[20]);
            chk($sformatf("%s_beat%0d", tag, i), a, exp_q[i]);
        end
    endtask

    initial begin
        RSTN = 1'b0; adc_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_ch_mask = '0; cfg_len = '0; cfg_decim = '0; cfg_test_mode = 1'b0;
        out_ready = 1'b0; clr_status = 1'b0; adc_data = '0;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        RSTN = 1'b1;
        step();

        // Basic capture: all channels, len 3, no decimation
        tb_clear();
        out_ready = 1'b1;
        begin_run(4'b1111, 3, 0, 1'b0);
        chk("basic_busy", 32'(busy), 32'd1);
        run_valids(3);
        wait_done("basic");
        add_set(0, 4'b1111, 1'b0, 1'b0);
        add_set(1, 4'b1111, 1'b0, 1'b0);
        add_set(2, 4'b1111, 1'b0, 1'b1);
        check_beats("basic");
        chk("basic_latency", 32'(first_ov_cyc - first_v_cyc), 32'd2);
        chk("basic_done_timing", 32'(done_cyc), 32'(last_beat_cyc + 2));
        chk("basic_idle_after", 32'(busy), 32'd0);
        repeat (3) step();
        chk("basic_done_once", 32'(done_cnt), 32'd1);

        // Masking and decimation: keep sets 0 and 3
        tb_clear();
        begin_run(4'b0101, 2, 2, 1'b0);
        run_valids(6);
        wait_done("decim");
        add_set(0, 4'b0101, 1'b0, 1'b0);
        add_set(3, 4'b0101, 1'b0, 1'b1);
        check_beats("decim");

        // Backpressure and overflow: 4 sets fit, 4 dropped
        tb_clear();
        out_ready = 1'b0;
        begin_run(4'b0110, 8, 0, 1'b0);
        run_valids(8);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) step();
        chk("bp_hold_ch", 32'(out_ch), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'(exp_val(0, 1, 1'b0)));
        out_ready = 1'b1;
        wait_done("bp");
        for (int s = 0; s < 4; s++) add_set(s, 4'b0110, 1'b0, s == 3);
        check_beats("bp");
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("bp_overflow_clr", 32'(overflow), 32'd0);

        // Abort mid-capture with overflow already set
        tb_clear();
        out_ready = 1'b0;
        begin_run(4'b1111, 10, 0, 1'b0);
        run_valids(6);
        chk("abort_pre_overflow", 32'(overflow), 32'd1);
        adc_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        adc_valid = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_overflow_kept", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (5) step();
        chk("abort_no_beats", 32'(beats.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;

        // Reset mid-capture
        tb_clear();
        out_ready = 1'b0;
        begin_run(4'b1111, 10, 0, 1'b0);
        run_valids(6);
        chk("rst2_pre_overflow", 32'(overflow), 32'd1);
        RSTN = 1'b0;
        step();
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_data",  32'(out_data),  32'd0);
        chk("rst2_out_ch",    32'(out_ch),    32'd0);
        chk("rst2_out_last",  32'(out_last),  32'd0);
        chk("rst2_busy",      32'(busy),      32'd0);
        chk("rst2_done",      32'(done),      32'd0);
        chk("rst2_overflow",  32'(overflow),  32'd0);
        RSTN = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        chk("rst2_stays_empty", 32'(beats.size()), 32'd0);

        // Zero length
        tb_clear();
        begin_run(4'b1111, 0, 0, 1'b0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (3) step();
        chk("len0_done_once", 32'(done_cnt), 32'd1);
        chk("len0_no_beats", 32'(beats.size()), 32'd0);

        // Zero mask
        tb_clear();
        begin_run(4'b0000, 5, 0, 1'b0);
        chk("mask0_done", 32'(done), 32'd1);
        repeat (3) step();
        chk("mask0_done_once", 32'(done_cnt), 32'd1);
        chk("mask0_no_beats", 32'(beats.size()), 32'd0);

        // Start while busy is ignored; test mode latched by the first start
        tb_clear();
        begin_run(4'b1111, 2, 0, 1'b1);
        adc_valid = 1'b1;
        step();
        cfg_ch_mask = 4'b0001;
        cfg_len = 16'd5;
        cfg_test_mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        adc_valid = 1'b0;
        wait_done("busy_start");
        add_set(0, 4'b1111, 1'b1, 1'b0);
        add_set(1, 4'b1111, 1'b1, 1'b1);
        check_beats("busy_start");
        repeat (3) step();
        chk("busy_start_done_once", 32'(done_cnt), 32'd1);
        chk("busy_start_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_mc.md
Name: adc_capture_mc

Overview:
- Parametrised multi-channel successor to the single 18-bit ADC capture path.
- Captures a programmed number of sample-sets from NUM_CH parallel ADC channels, with optional decimation.
- Buffers the sets in a FIFO and unpacks only the enabled channels into a valid/ready stream toward the readout/MDIO-side logic.
- Sits between the pad-side ADC data/valid inputs and the readout interface in the digital wrapper.

Parameters:
- NUM_CH, 4, number of ADC channels (1..8).
- DATA_W, 18, bits per channel sample.
- DEPTH, 64, FIFO depth in sample-sets (power of 2).
- LEN_W, 16, width of the capture-length counter.

Ports:
- CLK  in  1  single block clock.
- RSTN  in  1  reset; synchronous, active-low.
- adc_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- adc_valid  in  1  qualifies adc_data for one cycle.
- start  in  1  pulse; arms a capture.
- abort  in  1  pulse; cancels a capture.
- cfg_ch_mask  in  NUM_CH  enabled channels.
- cfg_len  in  LEN_W  sample-sets to capture.
- cfg_decim  in  8  keep 1 of every cfg_decim+1 valid sets.
- cfg_test_mode  in  1  selects test pattern; ignored without the macro.
- out_data  out  DATA_W  sample.
- out_ch  out  $clog2(NUM_CH) (min 1)  channel index of out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final beat of the capture.
- busy  out  1  capture or drain in progress.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; set on a dropped set.
- clr_status  in  1  clears overflow.

Behaviour:
- Reset (RSTN=0 at a CLK edge): all outputs 0, FIFO empty, state IDLE, counters 0.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start latches cfg_ch_mask, cfg_len and cfg_decim, then goes to CAPTURE.
  - If latched len==0 or mask==0, go straight back to IDLE and pulse done the next cycle; no beats are produced.
- CAPTURE:
  - Each adc_valid advances the decimation counter. The first valid after start is always kept; every subsequent (decim+1)-th valid is kept.
  - A kept set is written to the FIFO one cycle later, together with the latched mask.
  - If the FIFO is full at write time, the set is dropped and overflow is set. A dropped set still counts toward len (fixed time window).
  - When the kept count equals len, go to DRAIN.
- DRAIN:
  - Once the FIFO is empty and the unpacker is idle, go to IDLE and pulse done together with that transition.
- busy = (state != IDLE).
- Unpacker:
  - Pops one FIFO entry and emits enabled channels in ascending index, one beat per out_valid&&out_ready.
  - out_data, out_ch and out_valid hold while out_ready=0.
  - The next entry is popped in the same cycle the last beat of the current entry is accepted, so there are no bubbles.
  - out_last=1 only on the highest enabled channel of the final set.
- Latency: a kept adc_valid at cycle t, with the FIFO empty, gives out_valid at t+2.
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over everything: next cycle the FIFO is flushed, out_valid=0 and state is IDLE, with no done pulse. overflow is preserved.
  - clr_status and an overflow event in the same cycle: overflow ends at 1.
  - Config changes during a capture have no effect.
- Reset asserted mid-capture behaves like abort, and also clears overflow.
- The length counter is LEN_W wide; len = 2^LEN_W-1 is the maximum and does not wrap.

Optional Feature:
- Macro: ADC_CAPTURE_MC_TEST_PATTERN_EN.
- Defined: when cfg_test_mode=1 (latched at start), captured data for channel c = (c<<(DATA_W-3)) | set_index[DATA_W-4:0]. set_index starts at 0 and increments per kept set. Decimation and masking are unchanged.
- Not defined: cfg_test_mode is ignored and adc_data is always captured; no pattern logic is present.

Decomposition:
- Package adc_capture_mc_pkg holds:
  - state enum (IDLE, CAPTURE, DRAIN);
  - localparam CH_W = max(1, $clog2(NUM_CH));
  - FIFO entry width NUM_CH*DATA_W + NUM_CH;
  - pattern-format constants.
- Sub-module: adc_capture_mc_fifo, a synchronous FIFO with push/pop/full/empty/flush.
- Unpacker and FSM stay in the top-level block.

Test Plan:
- Basic capture:
  - Stimulus: NUM_CH=4, mask=4'b1111, len=3, decim=0, adc_valid every cycle, out_ready=1.
  - Response: 12 beats, out_ch 0,1,2,3 repeating; out_last on beat 12; done one cycle after the drain completes; first out_valid 2 cycles after the first valid.
- Masking and decimation:
  - Stimulus: mask=4'b0101, decim=2, len=2, adc_valid continuous.
  - Response: sets 0 and 3 kept; beats ch0,ch2,ch0,ch2; out_last on beat 4.
- Backpressure and overflow:
  - Stimulus: DEPTH=4, len=8, out_ready=0 until capture ends.
  - Response: 4 sets buffered; overflow=1; exactly 4×popcount(mask) beats after release; done still pulses; clr_status clears overflow.
- Abort and reset:
  - Stimulus: abort at set 2 of len=10.
  - Response: out_valid=0 next cycle, busy=0, no done. Repeat with RSTN=0 mid-capture: all outputs 0 the next cycle.
- Edge config:
  - Stimulus: start with len=0; start with mask=0; start while busy.
  - Response: done pulse with no beats for both zero cases; the start while busy is ignored and the current run is unchanged.
- Test pattern (macro on):
  - Stimulus: cfg_test_mode=1, NUM_CH=2, DATA_W=18, len=2, mask=2'b11.
  - Response: out_data sequence 0x00000, 0x08000, 0x00001, 0x08001.
